timer: RTL and testbench
========================

Name: timer

Overview:
- Parameterised down-counting interval timer for the RPN calculator, used for button debounce, display refresh and timeouts.
- Converts a requested period in ns/us/ms/s into a clock-cycle count at elaboration time.
- Emits a one-clock `done` pulse each time the period elapses.
- Supports one-shot operation (start pulsed) and free-running operation (start held high).

Parameters:
- CLK_PERIOD_ns, default 20: period of `clk` in ns; integer ≥ 1.
- TIMER_PERIOD_ns, default 100: requested timer period, expressed in the unit given by TIMER_PERIOD_TYPE.
- TIMER_PERIOD_TYPE, default "ns": unit string; one of "ns", "us", "ms", "s" (scale 1, 1e3, 1e6, 1e9).
- COUNT (localparam): TIMER_PERIOD_ns × scale / CLK_PERIOD_ns, integer floor, clamped to a minimum of 1. Defaults give COUNT = 5.
- CW (localparam): $clog2(COUNT+1); counter width.

Ports:
- clk, input, 1: rising-edge clock.
- reset, input, 1: asynchronous, active-high reset.
- enable, input, 1: count enable; low freezes the timer.
- sync_resetn, input, 1: synchronous, active-low clear.
- start, input, 1: level-sensitive start/run request.
- done, output, 1: registered one-cycle pulse when the period elapses.

Behaviour:
- State: IDLE or RUN, plus a CW-bit counter `cnt` and the `done` register.
- Async reset (reset = 1): state IDLE, `cnt` = 0, `done` = 0, immediately and regardless of `clk`.
- Per-edge priority: sync_resetn = 0 first, then enable = 0, then normal operation.
- sync_resetn = 0 at an edge: state IDLE, `cnt` = 0, `done` = 0.
- enable = 0 at an edge: state and `cnt` hold, `done` = 0, `start` ignored.
- IDLE, start = 1 at edge E0: go to RUN, `cnt` = COUNT−1, `done` = 0.
- IDLE, start = 0: stay in IDLE, `done` = 0.
- RUN, `cnt` ≠ 0: `cnt` decrements by 1, `done` = 0.
- RUN, `cnt` = 0: `done` = 1 for exactly one cycle.
  - If start = 1 at that edge: stay in RUN, `cnt` = COUNT−1 (free-run reload, no dead cycle).
  - If start = 0: go to IDLE.
- Latency: `done` rises exactly COUNT clock edges after the edge that sampled `start` high, i.e. COUNT × CLK_PERIOD_ns. Free-run period between `done` rising edges is exactly COUNT cycles.
- `start` is not a retrigger: while in RUN it is only examined at the `cnt` = 0 edge. Dropping `start` mid-period does not abort; the current period completes with one `done` pulse.
- `done` is never high two consecutive cycles unless COUNT = 1 and start is held high; in that case `done` stays high continuously.
- Enable dropped mid-count and restored: counting resumes from the held `cnt`, so total latency is extended by the disabled cycles.
- Reset or sync clear mid-count: the timer aborts, no `done` pulse, and it returns to IDLE.

Decomposition:
- Shared package `timer_pkg`:
  - function `unit_scale(string)` returning the ns multiplier;
  - function `cycles(period, type, clk_ns)` implementing the floor with clamp to 1;
  - state enum {IDLE, RUN}.
- Unsupported TIMER_PERIOD_TYPE triggers an elaboration-time $error.
- Single module; no sub-module is needed.

Test Plan:
- One-shot: defaults, async reset, then enable = 1 and sync_resetn = 1; start high for 2 cycles then low. Required: `done` rises exactly 100 ns (5 cycles) after the edge that sampled start, pulses one cycle, and never rises again.
- Free run: start held high. Required: first `done` rise 100 ns after the start-sampling edge, second rise 100 ns after the first, each pulse 1 cycle wide.
- Enable gating: drop enable for 3 cycles at `cnt` = 2. Required: `done` is delayed by exactly 3 cycles, i.e. arrives at 160 ns.
- Sync clear mid-count: sync_resetn = 0 for one cycle at `cnt` = 3. Required: no `done`; the timer is idle afterwards and restarts correctly on the next start.
- Async reset mid-count: pulse reset between edges. Required: `done` = 0 immediately and no pulse follows.
- Units: TIMER_PERIOD_TYPE = "us", TIMER_PERIOD_ns = 1, CLK_PERIOD_ns = 20. Required: COUNT = 50 and `done` arrives 1000 ns after start.

Source files
------------

// File: rtl/timer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : timer_pkg
// Description : Shared types and elaboration-time helpers for the interval
//               timer. These helpers convert a requested period and unit into
//               a clock-cycle count.
// Revision    : 1.0 - initial release
// ============================================================================
package timer_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Returns the ns multiplier for a unit string, or 0 when the unit is unknown.
    function automatic longint unit_scale(input string unit);
        if (unit == "ns") return 64'd1;
        if (unit == "us") return 64'd1000;
        if (unit == "ms") return 64'd1000000;
        if (unit == "s")  return 64'd1000000000;
        return 64'd0;
    endfunction

    // Floor of period*scale/clk_ns, clamped so the timer never has a zero period.
    function automatic int cycles(input longint period, input string unit,
                                  input longint clk_ns);
        longint c;
        c = (period * unit_scale(unit)) / clk_ns;
        if (c < 64'd1) c = 64'd1;
        return int'(c);
    endfunction

endpackage : timer_pkg
`default_nettype wire

// File: rtl/timer.sv
`default_nettype none
// ============================================================================
// Module      : timer
// Description : Down-counting interval timer. It issues a one-clock done pulse
//               COUNT cycles after start is sampled. When start is held high,
//               the timer free-runs with no dead cycle between periods.
// Revision    : 1.0 - initial release
// ============================================================================
module timer
    import timer_pkg::*;
#(
    parameter int    CLK_PERIOD_ns     = 20,
    parameter int    TIMER_PERIOD_ns   = 100,
    parameter string TIMER_PERIOD_TYPE = "ns"
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic sync_resetn,
    input  logic start,
    output logic done
);

    localparam int COUNT = cycles(longint'(TIMER_PERIOD_ns), TIMER_PERIOD_TYPE,
                                  longint'(CLK_PERIOD_ns));
    localparam int CW    = $clog2(COUNT + 1);
    localparam logic [CW-1:0] RELOAD = CW'(COUNT - 1);

    // Reject unit strings the scale table does not know.
    if (unit_scale(TIMER_PERIOD_TYPE) == 64'd0) begin : g_bad_unit
        $error("timer: unsupported TIMER_PERIOD_TYPE \"%s\"", TIMER_PERIOD_TYPE);
    end

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q,   cnt_d;
    logic            done_q,  done_d;

    // State register: asynchronous clear, otherwise load the next-state values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    // Next state: the sync clear has priority over the enable freeze. In RUN,
    // start matters only at the terminal count, so it cannot retrigger the timer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!sync_resetn) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (enable) begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = RUN;
                        cnt_d   = RELOAD;
                    end
                end
                RUN: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CW'(1);
                    end else if (start) begin
                        cnt_d = RELOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Output: pulse done on the enabled edge that leaves the terminal count.
    always_comb begin
        done_d = sync_resetn && enable && (state_q == RUN) && (cnt_q == '0);
    end

    assign done = done_q;

endmodule : timer
`default_nettype wire

// File: tb/tb_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_timer
// Description : Self-checking bench for timer. It runs a default-parameter
//               instance (5-cycle period) and a "us" instance (50-cycle period)
//               from the same stimulus. Both are compared each cycle against a
//               deadline-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_timer;

    logic clk = 1'b0;
    logic reset, enable, sync_resetn, start;
    logic done0, done1;

    always #10 clk = ~clk;

    timer u_dut0 (
        .clk(clk), .reset(reset), .enable(enable),
        .sync_resetn(sync_resetn), .start(start), .done(done0)
    );

    timer #(.CLK_PERIOD_ns(20), .TIMER_PERIOD_ns(1), .TIMER_PERIOD_TYPE("us")) u_dut1 (
        .clk(clk), .reset(reset), .enable(enable),
        .sync_resetn(sync_resetn), .start(start), .done(done1)
    );

    // Expected periods worked out by hand: 100ns/20ns and 1000ns/20ns.
    int period [2] = '{5, 50};

    int total = 0;
    int bad   = 0;

    // Reference model: busy flag plus the number of enabled edges left to the deadline.
    bit busy [2];
    int left [2];
    bit expd [2];

    int cyc = 0;
    int rise_cyc [2];
    int nrise [2];
    bit prev [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        if (obs !== expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    function automatic void model_clear();
        for (int i = 0; i < 2; i++) begin
            busy[i] = 1'b0;
            left[i] = 0;
            expd[i] = 1'b0;
        end
    endfunction

    function automatic void model_step(input bit st, input bit en, input bit srn);
        for (int i = 0; i < 2; i++) begin
            expd[i] = 1'b0;
            if (!srn) begin
                busy[i] = 1'b0;
            end else if (en) begin
                if (!busy[i]) begin
                    if (st) begin
                        busy[i] = 1'b1;
                        left[i] = period[i];
                    end
                end else begin
                    left[i]--;
                    if (left[i] == 0) begin
                        expd[i] = 1'b1;
                        if (st) left[i] = period[i];
                        else    busy[i] = 1'b0;
                    end
                end
            end
        end
    endfunction

    // One clock: drive inputs at negedge, step the model at posedge, compare 1ns later.
    task automatic tick(input bit st, input bit en, input bit srn);
        logic d [2];
        @(negedge clk);
        start = st; enable = en; sync_resetn = srn;
        @(posedge clk);
        cyc++;
        model_step(st, en, srn);
        #1;
        d[0] = done0;
        d[1] = done1;
        chk("done_dflt", done0, expd[0]);
        chk("done_us",   done1, expd[1]);
        for (int i = 0; i < 2; i++) begin
            if (d[i] && !prev[i]) begin
                rise_cyc[i] = cyc;
                nrise[i]++;
            end
            prev[i] = d[i];
        end
    endtask

    // Async reset pulse between edges; done must drop without waiting for clk.
    task automatic async_pulse();
        #4 reset = 1'b1;
        #1;
        chk("async_done_dflt", done0, 0);
        chk("async_done_us",   done1, 0);
        model_clear();
        prev[0] = 1'b0;
        prev[1] = 1'b0;
        #2 reset = 1'b0;
    endtask

    function automatic void clr_rise();
        for (int i = 0; i < 2; i++) begin
            nrise[i]    = 0;
            rise_cyc[i] = -1;
        end
    endfunction

    int s;

    initial begin
        reset = 1'b1; enable = 1'b0; sync_resetn = 1'b0; start = 1'b0;
        model_clear();
        clr_rise();
        prev[0] = 1'b0; prev[1] = 1'b0;
        #3;
        chk("reset_done_dflt", done0, 0);
        chk("reset_done_us",   done1, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) tick(0, 1, 1);

        // One-shot: start is high for 2 cycles; done must rise 5 edges after it is sampled.
        clr_rise();
        s = cyc + 1;
        tick(1, 1, 1);
        tick(1, 1, 1);
        repeat (12) tick(0, 1, 1);
        chk("oneshot_latency", rise_cyc[0] - s, 5);
        chk("oneshot_nrise",   nrise[0], 1);

        // Free run: two rises 5 cycles apart.
        clr_rise();
        s = cyc + 1;
        tick(1, 1, 1);
        repeat (5) tick(1, 1, 1);
        chk("freerun_first", rise_cyc[0] - s, 5);
        repeat (5) tick(1, 1, 1);
        chk("freerun_second", rise_cyc[0] - s, 10);
        // Release start one cycle early so the period in progress can finish.
        repeat (4) tick(0, 1, 1);
        repeat (6) tick(0, 1, 1);

        // Enable gating: disable 3 cycles when 2 counts remain; done lands 8 edges (160ns) after start.
        clr_rise();
        s = cyc + 1;
        tick(1, 1, 1);
        tick(0, 1, 1);
        tick(0, 1, 1);
        repeat (3) tick(0, 0, 1);
        repeat (6) tick(0, 1, 1);
        chk("enable_latency", rise_cyc[0] - s, 8);

        // Sync clear with 3 counts remaining: no done follows, and the next start works.
        clr_rise();
        tick(1, 1, 1);
        tick(0, 1, 1);
        tick(0, 1, 0);
        repeat (8) tick(0, 1, 1);
        chk("syncclr_nrise", nrise[0], 0);
        s = cyc + 1;
        tick(1, 1, 1);
        repeat (6) tick(0, 1, 1);
        chk("syncclr_restart", rise_cyc[0] - s, 5);

        // Async reset while done is high, then again mid-count: no pulse may follow.
        tick(1, 1, 1);
        repeat (5) tick(1, 1, 1);
        chk("pre_async_done", done0, 1);
        async_pulse();
        clr_rise();
        tick(1, 1, 1);
        tick(0, 1, 1);
        async_pulse();
        repeat (8) tick(0, 1, 1);
        chk("async_nrise", nrise[0], 0);

        // Units instance: done must arrive 50 edges (1000ns) after start.
        clr_rise();
        s = cyc + 1;
        tick(1, 1, 1);
        repeat (55) tick(0, 1, 1);
        chk("us_latency", rise_cyc[1] - s, 50);
        chk("us_nrise",   nrise[1], 1);

        // Randomised traffic, checked every cycle against the model.
        for (int k = 0; k < 600; k++) begin
            tick($urandom_range(0, 2) != 0,
                 $urandom_range(0, 5) != 0,
                 $urandom_range(0, 20) != 0);
            if ($urandom_range(0, 60) == 0) async_pulse();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_timer
`default_nettype wire
